// File: rtl/regfile_wr_sched.sv
// Write-port scheduler: fixed-priority pipeline writeback plus FIFO-buffered long-latency results.
// Optional macro REGFILE_WR_PASSTHRU_EN lets an LU write bypass an empty FIFO.
module regfile_wr_sched #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_num,
    input  logic [31:0]            wb_data,
    input  logic                   lu_valid,
    output logic                   lu_ready,
    input  logic [4:0]             lu_num,
    input  logic [31:0]            lu_data,
    output logic                   wr_en,
    output logic [4:0]             wr_num,
    output logic [31:0]            wr_data,
    output logic [31:0]            busy_mask,
    output logic                   stall_req,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_C  = WW'(MAX_WAIT);

    logic [36:0]   mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_en_q, wr_en_d, wr_lu_q, wr_lu_d;
    logic [4:0]    wr_num_q, wr_num_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          stall_q, stall_d;

    logic wb_req, fifo_empty, lu_real, pop, passthru, push;
    logic [36:0]   head;
    logic [PW-1:0] idx;

    // LU handshake: a transfer happens on an edge where lu_valid && lu_ready; lu_ready
    // depends only on the registered occupancy, never on a same-cycle pop.
    always_comb begin
        wb_req     = wb_valid && (wb_num != 5'd0);
        fifo_empty = (count_q == '0);
        lu_ready   = (count_q < DEPTH_C);
        lu_real    = lu_valid && lu_ready && (lu_num != 5'd0) && !flush;
        pop        = !wb_req && !fifo_empty && !flush;
`ifdef REGFILE_WR_PASSTHRU_EN
        passthru   = fifo_empty && !wb_req && lu_real;
`else
        passthru   = 1'b0;
`endif
        push       = lu_real && !passthru;
        head       = mem_q[rd_ptr_q];
    end

    always_comb begin
        wr_en_d   = 1'b0;
        wr_lu_d   = 1'b0;
        wr_num_d  = wr_num_q;
        wr_data_d = wr_data_q;
        if (wb_req) begin
            wr_en_d   = 1'b1;
            wr_num_d  = wb_num;
            wr_data_d = wb_data;
        end else if (pop) begin
            wr_en_d   = 1'b1;
            wr_lu_d   = 1'b1;
            wr_num_d  = head[36:32];
            wr_data_d = head[31:0];
        end else if (passthru) begin
            wr_en_d   = 1'b1;
            wr_lu_d   = 1'b1;
            wr_num_d  = lu_num;
            wr_data_d = lu_data;
        end

        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end

        // Reaching this else means the head is present and WB took the port.
        wait_d  = wait_q;
        stall_d = stall_q;
        if (flush || pop || fifo_empty) begin
            wait_d  = '0;
            stall_d = 1'b0;
        end else begin
            if (wait_q != WAIT_C) wait_d = wait_q + 1'b1;
            if (wait_d == WAIT_C) stall_d = 1'b1;
        end
    end

    always_comb begin
        busy_mask = '0;
        idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q) busy_mask[mem_q[idx][36:32]] = 1'b1;
        end
        if (wr_en_q && wr_lu_q) busy_mask[wr_num_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {lu_num, lu_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_lu_q   <= 1'b0;
            wr_num_q  <= '0;
            wr_data_q <= '0;
            wait_q    <= '0;
            stall_q   <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_lu_q   <= wr_lu_d;
            wr_num_q  <= wr_num_d;
            wr_data_q <= wr_data_d;
            wait_q    <= wait_d;
            stall_q   <= stall_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_num     = wr_num_q;
    assign wr_data    = wr_data_q;
    assign stall_req  = stall_q;
    assign fifo_count = count_q;
endmodule

// File: tb/tb_regfile_wr_sched.sv
// Bench for regfile_wr_sched: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_regfile_wr_sched;
    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;
`ifdef REGFILE_WR_PASSTHRU_EN
    localparam bit PT = 1'b1;
`else
    localparam bit PT = 1'b0;
`endif

    logic        clk, reset, flush;
    logic        wb_valid, lu_valid, lu_ready, wr_en, stall_req;
    logic [4:0]  wb_num, lu_num, wr_num;
    logic [31:0] wb_data, lu_data, wr_data, busy_mask;
    logic [2:0]  fifo_count;

    regfile_wr_sched #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .wb_valid(wb_valid), .wb_num(wb_num), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_num(lu_num), .lu_data(lu_data),
        .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
        .busy_mask(busy_mask), .stall_req(stall_req), .fifo_count(fifo_count)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: queued LU entries plus the expected output register
    logic [36:0] exp_q[$];
    logic [36:0] wr_log[$];
    logic        m_wr_en, m_wr_lu, m_stall;
    logic [4:0]  m_wr_num;
    logic [31:0] m_wr_data;
    int          m_wait;

    task automatic model_reset();
        exp_q.delete();
        m_wr_en = 0; m_wr_lu = 0; m_stall = 0; m_wr_num = 0; m_wr_data = 0; m_wait = 0;
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] m = '0;
        foreach (exp_q[i]) m[exp_q[i][36:32]] = 1'b1;
        if (m_wr_en && m_wr_lu) m[m_wr_num] = 1'b1;
        return m;
    endfunction

    task automatic model_edge();
        bit wb_req, accept, popped, consumed;
        int sz;
        logic [36:0] e;
        sz = exp_q.size();
        wb_req = wb_valid && (wb_num != 0);
        accept = lu_valid && (sz < DEPTH);
        popped = 0; consumed = 0;
        if (wb_req) begin
            m_wr_en = 1; m_wr_lu = 0; m_wr_num = wb_num; m_wr_data = wb_data;
        end else if (sz > 0 && !flush) begin
            e = exp_q.pop_front();
            m_wr_en = 1; m_wr_lu = 1; m_wr_num = e[36:32]; m_wr_data = e[31:0];
            popped = 1;
        end else if (PT && sz == 0 && accept && lu_num != 0 && !flush) begin
            m_wr_en = 1; m_wr_lu = 1; m_wr_num = lu_num; m_wr_data = lu_data;
            consumed = 1;
        end else begin
            m_wr_en = 0; m_wr_lu = 0;
        end
        if (flush || popped || sz == 0) begin
            m_wait = 0; m_stall = 0;
        end else begin
            m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
            if (m_wait == MAX_WAIT) m_stall = 1;
        end
        if (flush) exp_q.delete();
        else if (accept && lu_num != 0 && !consumed) exp_q.push_back({lu_num, lu_data});
    endtask

    task automatic compare_all();
        check("wr_en", wr_en, m_wr_en);
        check("wr_num", wr_num, m_wr_num);
        check("wr_data", wr_data, m_wr_data);
        check("fifo_count", fifo_count, exp_q.size());
        check("lu_ready", lu_ready, exp_q.size() < DEPTH);
        check("stall_req", stall_req, m_stall);
        check("busy_mask", busy_mask, model_busy());
    endtask

    // driver tasks
    task automatic drive(input logic f, input logic wv, input logic [4:0] wn, input logic [31:0] wd,
                         input logic lv, input logic [4:0] ln, input logic [31:0] ld);
        flush = f; wb_valid = wv; wb_num = wn; wb_data = wd;
        lu_valid = lv; lu_num = ln; lu_data = ld;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
        if (wr_en) wr_log.push_back({wr_num, wr_data});
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 30 && !(fifo_count == 0 && !wr_en); i++) step();
        check("drain", fifo_count, 0);
    endtask

    initial begin
        int n, acc_n, exp_lat;
        bit acc, hold;
        int exp_nums[4];
        logic [4:0] lu_seen[$];

        reset = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_num", wr_num, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy_mask, 0);
        check("rst_stall", stall_req, 0);
        reset = 1'b1;
        #1;
        check("rst_lu_ready", lu_ready, 1);

        // WB priority over a queued LU entry
        wr_log.delete();
        drive(0, 0, 0, 0, 1, 5'd5, 32'hAAAA5555); step();
        check("wbp_busy5", busy_mask[5], 1);
        drive(0, 1, 5'd1, 32'h11, 0, 0, 0); step();
        drive(0, 1, 5'd2, 32'h22, 0, 0, 0); step();
        drive(0, 1, 5'd3, 32'h33, 0, 0, 0); step();
        idle(); step(); step();
        check("wbp_busy_clear", busy_mask, 0);
        exp_nums = PT ? '{5, 1, 2, 3} : '{1, 2, 3, 5};
        check("wbp_writes", wr_log.size(), 4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
            check("wbp_order", wr_log[i][36:32], exp_nums[i]);
            if (wr_log[i][36:32] == 5'd5) check("wbp_r5_data", wr_log[i][31:0], 32'hAAAA5555);
        end

        // full FIFO: r8..r12 against continuous WB
        drain();
        wr_log.delete();
        acc_n = 0;
        for (int c = 0; c < 7; c++) begin
            drive(0, 1, 5'd20, 32'h2000 + c, acc_n < 5, 5'(8 + acc_n), 32'h800 + acc_n);
            acc = lu_valid && lu_ready;
            step();
            if (acc) acc_n++;
            if (c == 3) check("full_ready_low", lu_ready, 0);
        end
        check("full_accepts", acc_n, 4);
        for (int c = 0; c < 20 && !(acc_n == 5 && fifo_count == 0); c++) begin
            drive(0, 0, 0, 0, acc_n < 5, 5'(8 + acc_n), 32'h800 + acc_n);
            acc = lu_valid && lu_ready;
            step();
            if (acc) acc_n++;
        end
        check("full_all_accepted", acc_n, 5);
        idle(); step();
        lu_seen.delete();
        foreach (wr_log[i]) if (wr_log[i][36:32] >= 8 && wr_log[i][36:32] <= 12) lu_seen.push_back(wr_log[i][36:32]);
        check("full_lu_writes", lu_seen.size(), 5);
        for (int i = 0; i < 5 && i < lu_seen.size(); i++) check("full_order", lu_seen[i], 8 + i);

        // starvation
        drain();
        drive(0, 1, 5'd1, 32'h1, 1, 5'd7, 32'h777); step();
        n = 0;
        for (int c = 0; c < 20 && !stall_req; c++) begin
            drive(0, 1, 5'(1 + (c % 3)), 32'h100 + c, 0, 0, 0);
            step();
            n++;
        end
        check("stall_edges", n, MAX_WAIT);
        idle(); step();
        check("stall_pop_en", wr_en, 1);
        check("stall_pop_num", wr_num, 7);
        check("stall_pop_data", wr_data, 32'h777);
        check("stall_fall", stall_req, 0);

        // register 0
        drain();
        drive(0, 1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF); step();
        check("r0_no_write", wr_en, 0);
        check("r0_busy0", busy_mask[0], 0);
        drive(0, 0, 0, 0, 1, 5'd4, 32'h4444); step();
        idle();
        n = 1;
        for (int c = 0; c < 5 && !(wr_en && wr_num == 5'd4); c++) begin
            step();
            n++;
        end
        exp_lat = PT ? 1 : 2;
        check("r4_latency", n, exp_lat);
        check("r4_data", wr_data, 32'h4444);

        // flush with a simultaneous push
        drain();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 5'd2, 32'h20 + i, 1, 5'(13 + i), 32'hD00 + i);
            step();
        end
        check("flush_pre_count", fifo_count, 3);
        drive(1, 1, 5'd2, 32'h2F, 1, 5'd9, 32'h999); step();
        check("flush_count", fifo_count, 0);
        wr_log.delete();
        idle(); step();
        check("flush_busy", busy_mask, 0);
        step(); step();
        check("flush_no_lu_write", wr_log.size(), 0);

`ifdef REGFILE_WR_PASSTHRU_EN
        drain();
        drive(0, 0, 0, 0, 1, 5'd6, 32'h666); step();
        check("pt_en", wr_en, 1);
        check("pt_num", wr_num, 6);
        check("pt_count", fifo_count, 0);
`endif

        // reset mid-traffic with 3 entries queued
        drain();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 5'd3, 32'h30 + i, 1, 5'(16 + i), 32'hE00 + i);
            step();
        end
        #2;
        reset = 1'b0;
        #1;
        check("mrst_wr_en", wr_en, 0);
        check("mrst_count", fifo_count, 0);
        check("mrst_busy", busy_mask, 0);
        check("mrst_stall", stall_req, 0);
        idle();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mrst_lu_ready", lu_ready, 1);
        compare_all();

        // random traffic
        hold = 0;
        for (int c = 0; c < 2500; c++) begin
            flush = ($urandom_range(0, 49) == 0);
            if (stall_req) wb_valid = ($urandom_range(0, 19) == 0);
            else wb_valid = ($urandom_range(0, 99) < 55);
            wb_num  = 5'($urandom_range(0, 31));
            wb_data = $urandom;
            if (!hold) begin
                lu_valid = ($urandom_range(0, 99) < 50);
                lu_num   = 5'($urandom_range(0, 31));
                lu_data  = $urandom;
            end
            hold = lu_valid && !lu_ready;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/regfile_wr_sched.md
Name: regfile_wr_sched

Overview:
- Write-port scheduler in front of the 32x32 register file's single write port.
- Merges two writers onto that port:
  - In-order pipeline writeback (WB), which has fixed priority and no backpressure.
  - Long-latency unit (LU) results (mult/div, multi-cycle loads), which use a valid/ready handshake and are buffered in a small FIFO.
- Drives the register file's wr_en/wr_num/wr_data from registers.
- Exports a pending-write scoreboard and a starvation stall request to the hazard unit.

Parameters:
DEPTH, 4, LU FIFO entries (power of 2, 2..16)
MAX_WAIT, 8, consecutive cycles a non-empty FIFO head may be blocked by WB before stall_req asserts

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
flush  input  1  synchronous discard of all queued LU entries
wb_valid  input  1  pipeline writeback request
wb_num  input  5  WB destination register
wb_data  input  32  WB data
lu_valid  input  1  LU write request
lu_ready  output  1  FIFO can accept
lu_num  input  5  LU destination register
lu_data  input  32  LU data
wr_en  output  1  to register file write enable (registered)
wr_num  output  5  to register file write address (registered)
wr_data  output  32  to register file write data (registered)
busy_mask  output  32  bit r = LU write to r queued or in output register
stall_req  output  1  pipeline must hold wb_valid low
fifo_count  output  $clog2(DEPTH)+1  queued LU entries

Behaviour:
Reset (reset=0, async):
- wr_en=0, wr_num=0, wr_data=0.
- FIFO empty, fifo_count=0, busy_mask=0.
- stall_req=0, wait counter=0.
- lu_ready=1 once reset deasserts.

Arbitration, evaluated every rising edge; output registers load the winner:
1. wb_valid && wb_num!=0 -> wr_* <= WB, wr_en<=1.
2. Else FIFO non-empty -> pop head into wr_*, wr_en<=1.
3. Else wr_en<=0; wr_num/wr_data hold their previous values.

Register 0 handling:
- wb_num==0 counts as no request and never blocks the FIFO.
- LU pushes with lu_num==0 are accepted (handshake completes) but not queued.

Latency:
- WB presented in cycle c -> wr_en high in cycle c+1.
- LU accepted in cycle c -> earliest wr_en in cycle c+2.

LU handshake and FIFO:
- lu_ready = (fifo_count < DEPTH); no dependence on a same-cycle pop.
- Push on lu_valid && lu_ready. LU must hold lu_num/lu_data stable while lu_valid && !lu_ready.
- FIFO order is strict FIFO; pointers wrap modulo DEPTH.
- Full with a simultaneous pop: no push that cycle; fifo_count drops by 1.
- Simultaneous push and pop: fifo_count unchanged.

busy_mask:
- Combinational OR of one-hot(lu_num) over valid FIFO entries, plus the output register when it holds an LU write with wr_en=1.
- Duplicate destinations in the FIFO are allowed; the bit stays set until the last one retires.
- WB writes never set busy bits.
- The hazard unit guarantees WB never targets a busy register; no WAW resolution is done here.

Starvation (wait counter):
- Increments each edge on which the FIFO is non-empty and WB wins.
- Clears on any pop or when the FIFO is empty.
- When the counter reaches MAX_WAIT: stall_req<=1 (registered).
- While stall_req=1, the pipeline holds wb_valid=0 and the head pops.
- stall_req<=0 on the edge of that pop.
- If wb_valid arrives anyway while stall_req=1, WB still wins and stall_req stays high.

flush:
- On the edge with flush=1: FIFO emptied, counter cleared, stall_req<=0.
- Any LU push in the same cycle is dropped.
- WB arbitration that cycle proceeds normally.
- An already-registered wr_* is not cancelled; busy_mask keeps only that output-register contribution.

Reset mid-operation: all queued entries lost; outputs return to reset values immediately.

Optional Feature:
REGFILE_WR_PASSTHRU_EN
- Defined: when the FIFO is empty, wb_valid is not a real request, and an LU push occurs, the LU write loads wr_* directly on that edge without entering the FIFO.
  - fifo_count is unchanged.
  - LU latency becomes 1 cycle (accepted in c -> wr_en in c+1).
- Undefined: all LU writes pass through the FIFO; minimum LU latency is 2 cycles.

Test Plan:
- Reset: drive reset=0 mid-traffic with 3 entries queued -> wr_en=0, fifo_count=0, busy_mask=0, stall_req=0, lu_ready=1 after release.
- WB priority: cycle 0 LU push r5=0xAAAA5555; cycles 1-3 WB r1/r2/r3 -> wr_* shows r1, r2, r3, then r5=0xAAAA5555; busy_mask[5]=1 from cycle 1 until the cycle after r5 is written.
- Full FIFO: DEPTH=4, 5 back-to-back LU pushes r8..r12 with continuous WB -> lu_ready=0 after 4 accepts; r12 accepted only after the first pop; output order r8,r9,r10,r11,r12.
- Starvation: 1 LU entry r7, WB continuous -> stall_req rises after 8 blocked edges; bench drops wb_valid -> r7 written next cycle; stall_req falls on that edge.
- Register 0: WB r0 plus LU r0, then LU r4 -> no write for r0, busy_mask[0] never set, r4 written 2 cycles after accept.
- Flush: 3 entries queued, flush=1 with simultaneous LU push r9 -> fifo_count=0, no further wr_en from LU, busy_mask=0 one cycle later. With REGFILE_WR_PASSTHRU_EN: idle LU push r6 -> wr_en=1, wr_num=6 next cycle, fifo_count stays 0.
